// File: rtl/salu_instr_pkg.sv
// salu_instr_pkg: shared SGPR request/response/writeback types and inline-constant address bounds
package salu_instr_pkg;
  localparam int INLINE_ZERO    = 128;
  localparam int INLINE_POS_MAX = 192;
  localparam int INLINE_NEG_MAX = 208;
  typedef struct packed {
    logic [7:0] src0_addr;
    logic       src0_64;
    logic [7:0] src1_addr;
    logic       src1_64;
  } sgpr_rd_req_t;
  typedef struct packed {
    logic [63:0] src0_data;
    logic [63:0] src1_data;
    logic        err;
  } sgpr_rd_resp_t;
  typedef struct packed {
    logic [6:0]  addr;
    logic        is64;
    logic [63:0] data;
  } sgpr_wr_t;
endpackage

// File: rtl/sgpr_operand_decode.sv
// sgpr_operand_decode: maps one 8-bit source address to 64-bit operand data and an error flag
// Ports: addr_i/is64_i select the operand; lo_i/hi_i are the (bypassed) register pair; data_o/err_o result.
module sgpr_operand_decode
  import salu_instr_pkg::*;
(
  input  logic [7:0]  addr_i,
  input  logic        is64_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [63:0] data_o,
  output logic        err_o
);
  logic [31:0] neg;
  // 192 - addr yields -1..-16 for 193..208 in two's complement
  assign neg = 32'(INLINE_POS_MAX) - {24'b0, addr_i};
  assign err_o = addr_i > 8'(INLINE_NEG_MAX);
  assign data_o = !addr_i[7] ? {is64_i ? hi_i : 32'b0, lo_i}
                : addr_i <= 8'(INLINE_POS_MAX) ? {56'b0, addr_i - 8'(INLINE_ZERO)}
                : !err_o ? {is64_i ? {32{neg[31]}} : 32'b0, neg}
                : 64'b0;
endmodule

// File: rtl/sgpr_read_port.sv
// sgpr_read_port: scalar register file with dual-operand read port, write-first bypass and 2-entry response FIFO
// Ports: sgpr_rd_req_* (request in, valid/ready), sgpr_rd_resp_* (response out, valid/ready),
//        sgpr_wr_* (writeback in, always ready outside reset).
module sgpr_read_port
  import salu_instr_pkg::*;
#(
  parameter int NUM_SGPR = 128,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sgpr_rd_req_valid_i,
  output logic             sgpr_rd_req_ready_o,
  input  logic [7:0]       sgpr_rd_req_src0_addr_i,
  input  logic             sgpr_rd_req_src0_64_i,
  input  logic [7:0]       sgpr_rd_req_src1_addr_i,
  input  logic             sgpr_rd_req_src1_64_i,
  input  logic [TAG_W-1:0] sgpr_rd_req_tag_i,
  output logic             sgpr_rd_resp_valid_o,
  input  logic             sgpr_rd_resp_ready_i,
  output logic [63:0]      sgpr_rd_resp_src0_data_o,
  output logic [63:0]      sgpr_rd_resp_src1_data_o,
  output logic [TAG_W-1:0] sgpr_rd_resp_tag_o,
  output logic             sgpr_rd_resp_err_o,
  input  logic             sgpr_wr_valid_i,
  output logic             sgpr_wr_ready_o,
  input  logic [6:0]       sgpr_wr_addr_i,
  input  logic             sgpr_wr_is64_i,
  input  logic [63:0]      sgpr_wr_data_i
);
  logic [31:0] regs_q [NUM_SGPR];
  sgpr_rd_resp_t fifo_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [1:0] cnt_q, cnt_d;
  logic rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic push, pop, wr_fire, wr_hi_en;
  logic [6:0] wr_lo_a, wr_hi_a, a0, a1;
  logic [63:0] d0, d1;
  logic e0, e1;
  sgpr_rd_resp_t rsp;
  // Register lane as seen by a read this cycle: pending write wins
  function automatic logic [31:0] bp(input logic [6:0] i, input logic [31:0] q, input logic lo_en,
                                     input logic hi_en, input logic [6:0] lo_a, input logic [6:0] hi_a,
                                     input logic [63:0] d);
    return (lo_en && i == lo_a) ? d[31:0] : (hi_en && i == hi_a) ? d[63:32] : q;
  endfunction
  assign sgpr_wr_ready_o = !rst;
  assign wr_fire = sgpr_wr_valid_i && !rst;
  assign wr_hi_en = wr_fire && sgpr_wr_is64_i;
  assign wr_lo_a = sgpr_wr_is64_i ? {sgpr_wr_addr_i[6:1], 1'b0} : sgpr_wr_addr_i;
  assign wr_hi_a = {sgpr_wr_addr_i[6:1], 1'b1};
  assign a0 = sgpr_rd_req_src0_64_i ? {sgpr_rd_req_src0_addr_i[6:1], 1'b0} : sgpr_rd_req_src0_addr_i[6:0];
  assign a1 = sgpr_rd_req_src1_64_i ? {sgpr_rd_req_src1_addr_i[6:1], 1'b0} : sgpr_rd_req_src1_addr_i[6:0];
  sgpr_operand_decode u_dec0 (
    .addr_i (sgpr_rd_req_src0_addr_i),
    .is64_i (sgpr_rd_req_src0_64_i),
    .lo_i   (bp(a0, regs_q[a0], wr_fire, wr_hi_en, wr_lo_a, wr_hi_a, sgpr_wr_data_i)),
    .hi_i   (bp({a0[6:1], 1'b1}, regs_q[{a0[6:1], 1'b1}], wr_fire, wr_hi_en, wr_lo_a, wr_hi_a, sgpr_wr_data_i)),
    .data_o (d0),
    .err_o  (e0)
  );
  sgpr_operand_decode u_dec1 (
    .addr_i (sgpr_rd_req_src1_addr_i),
    .is64_i (sgpr_rd_req_src1_64_i),
    .lo_i   (bp(a1, regs_q[a1], wr_fire, wr_hi_en, wr_lo_a, wr_hi_a, sgpr_wr_data_i)),
    .hi_i   (bp({a1[6:1], 1'b1}, regs_q[{a1[6:1], 1'b1}], wr_fire, wr_hi_en, wr_lo_a, wr_hi_a, sgpr_wr_data_i)),
    .data_o (d1),
    .err_o  (e1)
  );
  assign rsp = '{src0_data: d0, src1_data: d1, err: e0 | e1};
  assign sgpr_rd_req_ready_o = !rst && cnt_q != 2'd2;
  assign sgpr_rd_resp_valid_o = !rst && cnt_q != 2'd0;
  assign push = sgpr_rd_req_valid_i && sgpr_rd_req_ready_o;
  assign pop = sgpr_rd_resp_valid_o && sgpr_rd_resp_ready_i;
  assign cnt_d = cnt_q + 2'(push) - 2'(pop);
  assign rd_ptr_d = rd_ptr_q ^ pop;
  assign wr_ptr_d = wr_ptr_q ^ push;
  assign sgpr_rd_resp_src0_data_o = fifo_q[rd_ptr_q].src0_data;
  assign sgpr_rd_resp_src1_data_o = fifo_q[rd_ptr_q].src1_data;
  assign sgpr_rd_resp_err_o = fifo_q[rd_ptr_q].err;
  assign sgpr_rd_resp_tag_o = tag_q[rd_ptr_q];
  always_ff @(posedge clk) begin
    if (wr_fire) regs_q[wr_lo_a] <= sgpr_wr_data_i[31:0];
    if (wr_hi_en) regs_q[wr_hi_a] <= sgpr_wr_data_i[63:32];
    if (push) begin
      fifo_q[wr_ptr_q] <= rsp;
      tag_q[wr_ptr_q] <= sgpr_rd_req_tag_i;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end
endmodule

// File: tb/tb_sgpr_read_port.sv
// tb_sgpr_read_port: directed self-checking bench for sgpr_read_port
module tb_sgpr_read_port;
  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, s0_64, s1_64;
  logic [7:0] s0_addr, s1_addr;
  logic [3:0] req_tag, resp_tag;
  logic resp_valid, resp_ready, resp_err;
  logic [63:0] resp_d0, resp_d1;
  logic wr_valid, wr_ready, wr_is64;
  logic [6:0] wr_addr;
  logic [63:0] wr_data;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  sgpr_read_port #(.NUM_SGPR(128), .TAG_W(4)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .sgpr_rd_req_valid_i      (req_valid),
    .sgpr_rd_req_ready_o      (req_ready),
    .sgpr_rd_req_src0_addr_i  (s0_addr),
    .sgpr_rd_req_src0_64_i    (s0_64),
    .sgpr_rd_req_src1_addr_i  (s1_addr),
    .sgpr_rd_req_src1_64_i    (s1_64),
    .sgpr_rd_req_tag_i        (req_tag),
    .sgpr_rd_resp_valid_o     (resp_valid),
    .sgpr_rd_resp_ready_i     (resp_ready),
    .sgpr_rd_resp_src0_data_o (resp_d0),
    .sgpr_rd_resp_src1_data_o (resp_d1),
    .sgpr_rd_resp_tag_o       (resp_tag),
    .sgpr_rd_resp_err_o       (resp_err),
    .sgpr_wr_valid_i          (wr_valid),
    .sgpr_wr_ready_o          (wr_ready),
    .sgpr_wr_addr_i           (wr_addr),
    .sgpr_wr_is64_i           (wr_is64),
    .sgpr_wr_data_i           (wr_data)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask
  task automatic req(input logic [7:0] a0, input logic w0, input logic [7:0] a1, input logic w1,
                     input logic [3:0] t);
    req_valid = 1'b1;
    s0_addr = a0;
    s0_64 = w0;
    s1_addr = a1;
    s1_64 = w1;
    req_tag = t;
  endtask
  task automatic wr(input logic [6:0] a, input logic w, input logic [63:0] d);
    wr_valid = 1'b1;
    wr_addr = a;
    wr_is64 = w;
    wr_data = d;
  endtask
  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    s0_addr = '0;
    s0_64 = 1'b0;
    s1_addr = '0;
    s1_64 = 1'b0;
    req_tag = '0;
    resp_ready = 1'b1;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_is64 = 1'b0;
    wr_data = '0;
    tick();
    tick();
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_wr_ready", 64'(wr_ready), 64'd1);
    wr(7'd5, 1'b0, 64'h0000_0000_DEAD_BEEF);
    tick();
    wr_valid = 1'b0;
    req(8'd5, 1'b0, 8'd129, 1'b0, 4'd1);
    tick();
    req_valid = 1'b0;
    chk("s5_valid", 64'(resp_valid), 64'd1);
    chk("s5_src0", resp_d0, 64'h0000_0000_DEAD_BEEF);
    chk("inl129_src1", resp_d1, 64'd1);
    chk("s5_err", 64'(resp_err), 64'd0);
    chk("s5_tag", 64'(resp_tag), 64'd1);
    tick();
    chk("s5_popped", 64'(resp_valid), 64'd0);
    wr(7'd11, 1'b1, 64'h1111_2222_3333_4444);
    tick();
    wr_valid = 1'b0;
    req(8'd10, 1'b1, 8'd11, 1'b0, 4'd2);
    tick();
    req_valid = 1'b0;
    chk("s10_64", resp_d0, 64'h1111_2222_3333_4444);
    chk("s11_32", resp_d1, 64'h0000_0000_1111_2222);
    req(8'd193, 1'b1, 8'd208, 1'b0, 4'd3);
    tick();
    chk("inl193_64", resp_d0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("inl208_32", resp_d1, 64'h0000_0000_FFFF_FFF0);
    chk("inl_err", 64'(resp_err), 64'd0);
    req(8'd220, 1'b0, 8'd128, 1'b1, 4'd4);
    tick();
    req_valid = 1'b0;
    chk("bad220_data", resp_d0, 64'd0);
    chk("bad220_err", 64'(resp_err), 64'd1);
    chk("inl128_64", resp_d1, 64'd0);
    chk("bad220_tag", 64'(resp_tag), 64'd4);
    req(8'd192, 1'b0, 8'd209, 1'b0, 4'd5);
    tick();
    req_valid = 1'b0;
    chk("inl192", resp_d0, 64'd64);
    chk("bad209_err", 64'(resp_err), 64'd1);
    wr(7'd3, 1'b0, 64'h55);
    req(8'd3, 1'b0, 8'd128, 1'b0, 4'd6);
    tick();
    wr_valid = 1'b0;
    req_valid = 1'b0;
    chk("bypass32", resp_d0, 64'h55);
    wr(7'd20, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
    req(8'd21, 1'b0, 8'd20, 1'b1, 4'd7);
    tick();
    wr_valid = 1'b0;
    req_valid = 1'b0;
    chk("bypass64_hi", resp_d0, 64'h0000_0000_AAAA_BBBB);
    chk("bypass64_pair", resp_d1, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    resp_ready = 1'b0;
    req(8'd129, 1'b0, 8'd128, 1'b0, 4'd1);
    tick();
    chk("bp_ready_1", 64'(req_ready), 64'd1);
    req(8'd130, 1'b0, 8'd128, 1'b0, 4'd2);
    tick();
    chk("bp_ready_full", 64'(req_ready), 64'd0);
    req(8'd131, 1'b0, 8'd128, 1'b0, 4'd3);
    wr(7'd3, 1'b0, 64'h77);
    tick();
    wr_valid = 1'b0;
    chk("bp_still_full", 64'(req_ready), 64'd0);
    chk("bp_head_tag1", 64'(resp_tag), 64'd1);
    chk("bp_head_d1", resp_d0, 64'd1);
    resp_ready = 1'b1;
    tick();
    chk("bp_head_tag2", 64'(resp_tag), 64'd2);
    chk("bp_head_d2", resp_d0, 64'd2);
    chk("bp_ready_one", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_head_tag3", 64'(resp_tag), 64'd3);
    chk("bp_head_d3", resp_d0, 64'd3);
    chk("bp_pushpop_ready", 64'(req_ready), 64'd1);
    chk("bp_pushpop_valid", 64'(resp_valid), 64'd1);
    tick();
    chk("bp_drained", 64'(resp_valid), 64'd0);
    req(8'd3, 1'b0, 8'd128, 1'b0, 4'd8);
    tick();
    req_valid = 1'b0;
    chk("s3_after_write", resp_d0, 64'h77);
    tick();
    resp_ready = 1'b0;
    req(8'd129, 1'b0, 8'd128, 1'b0, 4'd4);
    tick();
    req(8'd130, 1'b0, 8'd128, 1'b0, 4'd5);
    tick();
    req_valid = 1'b0;
    chk("rst2_full", 64'(req_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("rst2_valid_in_rst", 64'(resp_valid), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_valid_after", 64'(resp_valid), 64'd0);
    chk("rst2_ready_after", 64'(req_ready), 64'd1);
    resp_ready = 1'b1;
    req(8'd135, 1'b0, 8'd128, 1'b0, 4'd7);
    tick();
    req_valid = 1'b0;
    chk("rst2_resp_valid", 64'(resp_valid), 64'd1);
    chk("rst2_resp_tag", 64'(resp_tag), 64'd7);
    chk("rst2_resp_d0", resp_d0, 64'd7);
    tick();
    chk("rst2_single", 64'(resp_valid), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
